async_block_driver: RTL and testbench

- Initiator side of the proc/rdy handshake into the 4-operand asynchronous compute block.
- Holds four 4-bit operand slots loaded from switch data plus per-slot strobes.
- On a start request, drives the operands and runs a 4-phase return-to-zero handshake.
- Captures the 4-bit result, reports busy/valid/error status, and counts completed transactions; result feeds the 7-segment display path.

---
 rtl/async_block_driver_pkg.sv | 26 ++
 rtl/async_block_driver_if.sv | 29 ++
 rtl/async_block_driver_rdy_sync.sv | 26 ++
 rtl/async_block_driver.sv | 159 +++++++++++++++
 tb/tb_async_block_driver.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_block_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : async_block_driver_pkg
// Purpose  : Shared widths and FSM encoding for the async block driver.
// Revision : 1.0 - initial release
// ============================================================================
package async_block_driver_pkg;

  localparam int c_data_w = 4;

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_req  = 3'd1;
  localparam logic [2:0] c_st_capt = 3'd2;
  localparam logic [2:0] c_st_rtz  = 3'd3;
  localparam logic [2:0] c_st_err  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = c_st_idle,
    REQ  = c_st_req,
    CAPT = c_st_capt,
    RTZ  = c_st_rtz,
    ERR  = c_st_err
  } state_t;

endpackage
`default_nettype wire

// File: rtl/async_block_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : async_block_driver_if
// Purpose  : Bundled-data proc/rdy link to the 4-operand compute block.
// Revision : 1.0 - initial release
// ============================================================================
interface async_block_driver_if;
  import async_block_driver_pkg::*;

  logic [c_data_w-1:0] blk_in1;
  logic [c_data_w-1:0] blk_in2;
  logic [c_data_w-1:0] blk_in3;
  logic [c_data_w-1:0] blk_in4;
  logic                blk_proc;
  logic                blk_rdy;
  logic [c_data_w-1:0] blk_out;

  modport master (
    output blk_in1, blk_in2, blk_in3, blk_in4, blk_proc,
    input  blk_rdy, blk_out
  );

  modport slave (
    input  blk_in1, blk_in2, blk_in3, blk_in4, blk_proc,
    output blk_rdy, blk_out
  );

endinterface
`default_nettype wire

// File: rtl/async_block_driver_rdy_sync.sv
`default_nettype none
// ============================================================================
// Module   : rdy_sync
// Purpose  : Multi-flop synchroniser for asynchronous return signals.
// Revision : 1.0 - initial release
// ============================================================================
module rdy_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_block_driver.sv
`default_nettype none
// ============================================================================
// Module   : async_block_driver
// Purpose  : Initiator of the 4-phase proc/rdy handshake with operand slots,
//            result capture, status flags and a transaction counter.
// Revision : 1.0 - initial release
// ============================================================================
module async_block_driver
  import async_block_driver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [c_data_w-1:0] op_in,
  input  logic [3:0]          op_ld,
  input  logic                go,
  input  logic                auto,
  async_block_driver_if.master blk,
  output logic [c_data_w-1:0] res,
  output logic                res_valid,
  output logic                busy,
  output logic                err,
  output logic [3:0]          done_cnt
);

  logic                 w_rst_n;
  logic                 w_rdy_s;
  logic                 w_go_rise;
  logic                 w_start;
  logic                 w_timeout;
  logic [TIMEOUT_W-1:0] w_timer_nxt;

  state_t                    r_state;
  logic [3:0][c_data_w-1:0]  r_slot;
  logic [TIMEOUT_W-1:0]      r_timer;
  logic [c_data_w-1:0]       r_res;
  logic [3:0]                r_done_cnt;
  logic                      r_go_q;
  logic                      r_pending;
  logic                      r_blk_proc;
  logic                      r_busy;
  logic                      r_err;
  logic                      r_res_valid;

  // Reset asserts asynchronously but releases on a clock edge.
  rdy_sync #(.STAGES(2)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (w_rst_n)
  );

  rdy_sync #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk   (clk),
    .rst_n (w_rst_n),
    .d     (blk.blk_rdy),
    .q     (w_rdy_s)
  );

  assign w_go_rise   = go & ~r_go_q;
  assign w_start     = (r_pending | (auto & r_res_valid & ~r_err)) & ~w_rdy_s;
  assign w_timer_nxt = (&r_timer) ? r_timer : r_timer + 1'b1;
  assign w_timeout   = &w_timer_nxt;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_slot <= '0;
    end else if (!r_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (op_ld[k]) r_slot[k] <= op_in;
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_res       <= '0;
      r_done_cnt  <= '0;
      r_go_q      <= 1'b0;
      r_pending   <= 1'b0;
      r_blk_proc  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_go_q <= go;
      if (w_go_rise && !r_busy) r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= REQ;
            r_blk_proc <= 1'b1;
            r_busy     <= 1'b1;
            r_timer    <= '0;
            r_pending  <= 1'b0;
          end
        end
        REQ: begin
          if (w_rdy_s) begin
            r_state    <= CAPT;
            r_blk_proc <= 1'b0;
          end else if (w_timeout) begin
            r_state     <= ERR;
            r_blk_proc  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b1;
            r_res_valid <= 1'b0;
          end else begin
            r_timer <= w_timer_nxt;
          end
        end
        // rdy_s is still high here, so blk_out is guaranteed settled.
        CAPT: begin
          r_res       <= blk.blk_out;
          r_res_valid <= 1'b1;
          r_err       <= 1'b0;
          r_done_cnt  <= r_done_cnt + 1'b1;
          r_timer     <= '0;
          r_state     <= RTZ;
        end
        RTZ: begin
          if (!w_rdy_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_timeout) begin
            r_state     <= ERR;
            r_busy      <= 1'b0;
            r_err       <= 1'b1;
            r_res_valid <= 1'b0;
          end else begin
            r_timer <= w_timer_nxt;
          end
        end
        ERR: begin
          if (r_pending) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign blk.blk_in1  = r_slot[0];
  assign blk.blk_in2  = r_slot[1];
  assign blk.blk_in3  = r_slot[2];
  assign blk.blk_in4  = r_slot[3];
  assign blk.blk_proc = r_blk_proc;
  assign res          = r_res;
  assign res_valid    = r_res_valid;
  assign busy         = r_busy;
  assign err          = r_err;
  assign done_cnt     = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_async_block_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_block_driver
// Purpose  : Directed self-checking bench with a behavioural compute-block
//            responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_block_driver;
  import async_block_driver_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [c_data_w-1:0] op_in;
  logic [3:0]          op_ld;
  logic                go;
  logic                auto;
  logic [c_data_w-1:0] res;
  logic                res_valid;
  logic                busy;
  logic                err;
  logic [3:0]          done_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Responder: mode 0 never acks, 1 normal, 2 rdy follows rdy_force.
  int                  resp_mode  = 1;
  int                  resp_delay = 5;
  int                  resp_hold  = 0;
  logic [c_data_w-1:0] resp_val   = 4'hA;
  logic                rdy_force  = 1'b0;
  int                  proc_cnt   = 0;
  int                  hold_cnt   = 0;

  async_block_driver_if bus ();

  async_block_driver #(.SYNC_STAGES(2), .TIMEOUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_in     (op_in),
    .op_ld     (op_ld),
    .go        (go),
    .auto      (auto),
    .blk       (bus.master),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy),
    .err       (err),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.blk_rdy = 1'b0;
      bus.blk_out = '0;
      proc_cnt    = 0;
      hold_cnt    = 0;
    end else if (resp_mode == 0) begin
      bus.blk_rdy = 1'b0;
    end else if (resp_mode == 2) begin
      bus.blk_rdy = rdy_force;
    end else if (bus.blk_proc && !bus.blk_rdy) begin
      if (proc_cnt >= resp_delay) begin
        bus.blk_out = resp_val;
        bus.blk_rdy = 1'b1;
        proc_cnt    = 0;
      end else begin
        proc_cnt++;
      end
    end else if (!bus.blk_proc && bus.blk_rdy) begin
      if (hold_cnt >= resp_hold) begin
        bus.blk_rdy = 1'b0;
        hold_cnt    = 0;
      end else begin
        hold_cnt++;
      end
    end else begin
      proc_cnt = 0;
      hold_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] probe(input int which);
    case (which)
      0:       return {3'b0, busy};
      1:       return {3'b0, bus.blk_proc};
      2:       return {3'b0, err};
      3:       return {3'b0, res_valid};
      default: return done_cnt;
    endcase
  endfunction

  // Waits for a status value; the final check fails if the bound expires.
  task automatic wait_on(input int which, input logic [3:0] val, input int lim,
                         input string tag, output int n);
    n = 0;
    while (probe(which) !== val && n < lim) begin
      tick(1);
      n++;
    end
    check(tag, probe(which), val);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic load(input logic [3:0] mask, input logic [c_data_w-1:0] val);
    op_in = val;
    op_ld = mask;
    tick(1);
    op_ld = 4'b0000;
  endtask

  function automatic logic [15:0] slots();
    return {bus.blk_in4, bus.blk_in3, bus.blk_in2, bus.blk_in1};
  endfunction

  initial begin
    int n;
    int incs;
    logic wrapped;
    logic [3:0] prev;

    rst_n = 1'b0;
    op_in = '0;
    op_ld = '0;
    go    = 1'b0;
    auto  = 1'b0;
    tick(3);
    check("rst_proc", bus.blk_proc, 1'b0);
    check("rst_status", {busy, err, res_valid}, 3'b000);
    check("rst_res_cnt", {res, done_cnt}, 8'h00);
    check("rst_slots", slots(), 16'h0000);
    rst_n = 1'b1;
    tick(4);

    // Basic transaction with latency check
    load(4'b0001, 4'd3);
    load(4'b0010, 4'd5);
    load(4'b0100, 4'd7);
    load(4'b1000, 4'd9);
    tick(1);
    check("slots_load", slots(), 16'h9753);
    go = 1'b1;
    tick(1);
    check("proc_lat1", bus.blk_proc, 1'b0);
    tick(1);
    check("proc_lat2", {bus.blk_proc, busy}, 2'b11);
    go = 1'b0;
    wait_on(3, 4'd1, 50, "t1_res_valid", n);
    check("t1_res", res, 4'hA);
    check("t1_cnt", done_cnt, 4'd1);
    check("t1_proc_low", bus.blk_proc, 1'b0);
    wait_on(0, 4'd0, 50, "t1_busy_fall", n);
    check("t1_rdy_low_at_idle", bus.blk_rdy, 1'b0);

    // Loads dropped while busy, accepted once idle
    resp_delay = 20;
    resp_val   = 4'h5;
    pulse_go();
    wait_on(1, 4'd1, 10, "t2_proc", n);
    load(4'b1111, 4'd6);
    check("t2_slots_busy", slots(), 16'h9753);
    wait_on(0, 4'd0, 100, "t2_busy_fall", n);
    check("t2_res_cnt", {res, done_cnt}, 8'h52);
    load(4'b1111, 4'd6);
    tick(1);
    check("t2_slots_idle", slots(), 16'h6666);

    // REQ timeout, then recovery
    resp_mode = 0;
    pulse_go();
    wait_on(1, 4'd1, 10, "t3_proc", n);
    wait_on(2, 4'd1, 400, "t3_err", n);
    check("t3_timeout_cycles", n, 255);
    check("t3_err_status", {bus.blk_proc, busy, res_valid}, 3'b000);
    check("t3_res_kept", res, 4'h5);
    resp_mode  = 1;
    resp_delay = 3;
    resp_val   = 4'hB;
    pulse_go();
    wait_on(3, 4'd1, 50, "t3_recover_valid", n);
    check("t3_recover", {err, res, done_cnt}, 9'h0B3);
    wait_on(0, 4'd0, 50, "t3_busy_fall", n);

    // rdy already high at go holds the start in IDLE
    resp_mode = 2;
    rdy_force = 1'b1;
    resp_val  = 4'h7;
    tick(4);
    pulse_go();
    tick(5);
    check("t4_hold_idle", {bus.blk_proc, busy}, 2'b00);
    resp_mode = 1;
    wait_on(1, 4'd1, 10, "t4_proc_after_rdy_low", n);
    wait_on(0, 4'd0, 50, "t4_busy_fall", n);
    check("t4_res_cnt", {res, done_cnt}, 8'h74);

    // Auto re-issue, 16 transactions wrap the counter back to 4
    resp_delay = 1;
    resp_val   = 4'hC;
    auto       = 1'b1;
    incs       = 0;
    wrapped    = 1'b0;
    prev       = done_cnt;
    for (int i = 0; i < 2000 && incs < 16; i++) begin
      tick(1);
      if (done_cnt != prev) begin
        incs++;
        if (prev == 4'd15 && done_cnt == 4'd0) wrapped = 1'b1;
        prev = done_cnt;
      end
    end
    auto = 1'b0;
    check("t5_incs", incs, 16);
    check("t5_wrapped", wrapped, 1'b1);
    wait_on(0, 4'd0, 50, "t5_busy_fall", n);
    tick(5);
    check("t5_stopped", {busy, res, done_cnt}, 9'h0C4);

    // rdy held after capture stalls in RTZ
    resp_hold = 20;
    resp_val  = 4'h3;
    pulse_go();
    wait_on(4, 4'd5, 50, "t6_capt", n);
    tick(10);
    check("t6_rtz_stall", {busy, bus.blk_proc}, 2'b10);
    wait_on(0, 4'd0, 60, "t6_busy_fall", n);
    check("t6_err_clear", err, 1'b0);

    // RTZ timeout
    resp_hold = 1000;
    resp_val  = 4'h8;
    pulse_go();
    wait_on(2, 4'd1, 400, "t7_rtz_err", n);
    check("t7_status", {busy, res_valid, res, done_cnt}, 10'h086);
    resp_hold = 0;
    tick(5);

    // Asynchronous reset in REQ
    resp_mode = 0;
    pulse_go();
    wait_on(1, 4'd1, 10, "t8_proc", n);
    #2 rst_n = 1'b0;
    #1;
    check("t8_async_rst", {bus.blk_proc, busy, res_valid, done_cnt}, 7'h00);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("t8_after_rst", {busy, err, done_cnt}, 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
